// File: rtl/rsa_encryption.sv
// Toy RSA encryptor: c = m^E mod N using a right-to-left square-and-multiply
// engine. It always runs EXP_W iterations, so latency does not depend on the data.
//
//   state | meaning
//   IDLE  | waiting for plaintext, m_ready high
//   CALC  | one exponent bit per clock, EXP_W clocks in total
//   DONE  | ciphertext presented, held until c_ready
module rsa_encryption #(
  parameter int WIDTH = 8,
  parameter int N_MOD = 143,
  parameter int E_EXP = 7,
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] m_in,
  input  logic             m_valid,
  output logic             m_ready,
  output logic [WIDTH-1:0] c_out,
  output logic             c_valid,
  input  logic             c_ready,
  output logic             busy
);

  localparam int CNT_W = $clog2(EXP_W) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(EXP_W - 1);
  localparam logic [WIDTH-1:0]   N_NARROW = WIDTH'(N_MOD);
  localparam logic [2*WIDTH-1:0] N_WIDE   = (2*WIDTH)'(N_MOD);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   result_q;
  logic [WIDTH-1:0]   base_q;
  logic [EXP_W-1:0]   exp_q;
  logic [CNT_W-1:0]   count_q;
  logic               m_ready_q;
  logic               c_valid_q;
  logic               busy_q;
  logic [WIDTH-1:0]   c_out_q;

  logic [2*WIDTH-1:0] prod_rb;
  logic [2*WIDTH-1:0] prod_bb;
  logic [WIDTH-1:0]   result_mul_d;
  logic [WIDTH-1:0]   base_sq_d;
  logic [WIDTH-1:0]   base_in_d;

  // Full-width products, reduced mod N; both use the pre-update register values
  assign prod_rb      = {{WIDTH{1'b0}}, result_q} * {{WIDTH{1'b0}}, base_q};
  assign prod_bb      = {{WIDTH{1'b0}}, base_q} * {{WIDTH{1'b0}}, base_q};
  assign result_mul_d = WIDTH'(prod_rb % N_WIDE);
  assign base_sq_d    = WIDTH'(prod_bb % N_WIDE);
  // Inputs at or above the modulus are folded back into range before use
  assign base_in_d    = m_in % N_NARROW;

  // Sequencer and datapath. Every output comes straight from a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      base_q    <= '0;
      exp_q     <= '0;
      count_q   <= '0;
      m_ready_q <= 1'b1;
      c_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      c_out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m_valid && m_ready_q) begin
            base_q    <= base_in_d;
            result_q  <= WIDTH'(1);
            exp_q     <= EXP_W'(E_EXP);
            count_q   <= '0;
            m_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          if (exp_q[0]) begin
            result_q <= result_mul_d;
          end
          base_q  <= base_sq_d;
          exp_q   <= exp_q >> 1;
          count_q <= count_q + CNT_W'(1);
          // No early exit on exp == 0; the iteration count is fixed
          if (count_q == CNT_LAST) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          // The first DONE clock publishes the result; after that, wait for the sink
          if (!c_valid_q) begin
            c_valid_q <= 1'b1;
            c_out_q   <= result_q;
          end else if (c_ready) begin
            c_valid_q <= 1'b0;
            m_ready_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_ready = m_ready_q;
  assign c_valid = c_valid_q;
  assign c_out   = c_out_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_rsa_encryption.sv
// Bench for rsa_encryption: directed vectors, backpressure, busy-input, reset
// mid-operation, random plaintexts and a full encrypt/decrypt round trip.
module tb_rsa_encryption;

  localparam int N     = 143;
  localparam int E     = 7;
  localparam int D     = 103;
  localparam int LAT   = 9;
  localparam int BOUND = 40;

  logic       clk;
  logic       reset;
  logic [7:0] m_in;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] c_out;
  logic       c_valid;
  logic       c_ready;
  logic       busy;

  int n_checks;
  int n_fail;

  rsa_encryption #(.WIDTH(8), .N_MOD(N), .E_EXP(E), .EXP_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .m_in    (m_in),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .c_out   (c_out),
    .c_valid (c_valid),
    .c_ready (c_ready),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: exponentiation as plain repeated multiplication
  function automatic int modpow(input int b, input int e, input int n);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * (b % n)) % n;
    return r;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one word and release m_valid right after the accepting edge
  task automatic start(input int m);
    @(negedge clk);
    chk("ready_before_accept", int'(m_ready), 1);
    m_in    = 8'(m);
    m_valid = 1'b1;
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  // Count clock edges until c_valid is seen; the count is capped at BOUND
  task automatic wait_valid(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!c_valid && edges < BOUND);
  endtask

  task automatic handshake();
    @(posedge clk);
    #1;
    chk("cvalid_drop", int'(c_valid), 0);
    chk("mready_back", int'(m_ready), 1);
    chk("busy_drop", int'(busy), 0);
  endtask

  task automatic encrypt(input int m, input int exp_c, output int got_c);
    int e;
    start(m);
    wait_valid(e);
    chk("latency", e, LAT);
    got_c = int'(c_out);
    chk("c_out", got_c, exp_c);
    handshake();
  endtask

  initial begin
    int c, e, seen, m, dec;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    m_valid  = 1'b0;
    m_in     = '0;
    c_ready  = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_ready", int'(m_ready), 1);
    chk("rst_c_valid", int'(c_valid), 0);
    chk("rst_c_out", int'(c_out), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;

    // Basic case and directed vectors
    encrypt(2, 128, c);
    chk("model_2", modpow(2, E, N), 128);
    encrypt(9, 48, c);
    encrypt(150, 6, c);
    encrypt(0, 0, c);
    encrypt(1, 1, c);
    encrypt(142, 142, c);
    encrypt(143, 0, c);

    // Backpressure: the result must hold while c_ready is low
    c_ready = 1'b0;
    start(9);
    wait_valid(e);
    chk("bp_latency", e, LAT);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("bp_c_valid", int'(c_valid), 1);
      chk("bp_c_out", int'(c_out), 48);
      chk("bp_m_ready", int'(m_ready), 0);
    end
    @(negedge clk);
    c_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drop", int'(c_valid), 0);
    chk("bp_retain", int'(c_out), 48);

    // m_valid toggling while busy is ignored
    start(9);
    e = 0;
    do begin
      @(negedge clk);
      m_in    = 8'd5;
      m_valid = ~m_valid;
      @(posedge clk);
      #1;
      e++;
    end while (!c_valid && e < BOUND);
    chk("busy_latency", e, LAT);
    chk("busy_c_out", int'(c_out), 48);
    @(negedge clk);
    m_valid = 1'b1;
    m_in    = 8'd5;
    @(posedge clk);
    #1;
    chk("busy_hs_cvalid", int'(c_valid), 0);
    chk("busy_hs_mready", int'(m_ready), 1);
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    chk("busy_accept5", int'(m_ready), 0);
    wait_valid(e);
    chk("busy5_latency", e, LAT);
    chk("busy5_c_out", int'(c_out), modpow(5, E, N));
    handshake();

    // Reset during CALC discards the computation
    start(2);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_c_valid", int'(c_valid), 0);
    chk("mid_rst_m_ready", int'(m_ready), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_c_out", int'(c_out), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (c_valid) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);
    encrypt(2, 128, c);

    // Random plaintexts over the full input range
    for (int i = 0; i < 30; i++) begin
      m = int'($urandom_range(0, 255));
      encrypt(m, modpow(m, E, N), c);
    end

    // Round trip through the d = 103 decryption
    for (int i = 0; i < N; i++) begin
      encrypt(i, modpow(i, E, N), c);
      dec = modpow(c, D, N);
      chk("roundtrip", dec, i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
